// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ModeUnicast,
        ModeBroadcast,
        ModeDrop
    } route_mode_e;

    // Widest drop counter supported; narrower counters truncate this.
    localparam logic [63:0] DROP_SAT = '1;

    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/demux_channel_reg.sv
// One-entry holding register for a single demux output channel.
module demux_channel_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  free_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && out_ready_i) begin
            // Clear on drain so idle lines never show stale data.
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;
    assign free_o      = !valid_q || out_ready_i;

endmodule

// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N valid/ready demultiplexer with broadcast and out-of-range drop counting.
module stream_demux_1_to_n
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned SEL_WIDTH      = $clog2(NUM_CHANNELS),
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic [SEL_WIDTH-1:0]               select_lines,
    input  logic                               broadcast,
    output logic [NUM_CHANNELS-1:0]            out_valid,
    input  logic [NUM_CHANNELS-1:0]            out_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] output_lines,
    output logic                               drop_err,
    output logic [DROP_CNT_WIDTH-1:0]          drop_count
);

    localparam logic [DROP_CNT_WIDTH-1:0] DropSat = DROP_CNT_WIDTH'(DROP_SAT);

    logic [NUM_CHANNELS-1:0]   sel_hit;
    logic [NUM_CHANNELS-1:0]   free;
    logic [NUM_CHANNELS-1:0]   load;
    route_mode_e               mode;
    logic                      accept;
    logic                      drop;
    logic                      drop_err_q;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    // Decoding by compare keeps non-power-of-two channel counts safe.
    always_comb begin
        sel_hit = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            sel_hit[i] = (32'(select_lines) == i);
        end
    end

    always_comb begin
        if (broadcast) begin
            mode = ModeBroadcast;
        end else if (|sel_hit) begin
            mode = ModeUnicast;
        end else begin
            mode = ModeDrop;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        unique case (mode)
            ModeBroadcast: in_ready = &free;
            ModeUnicast:   in_ready = |(sel_hit & free);
            ModeDrop:      in_ready = 1'b1;
            default:       in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign drop   = accept && (mode == ModeDrop);

    always_comb begin
        load = '0;
        if (accept) begin
            load = (mode == ModeBroadcast) ? '1 : sel_hit;
        end
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != DropSat)) begin
            drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_err_q   <= drop;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_err   = drop_err_q;
    assign drop_count = drop_count_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        localparam int unsigned Lo = slice_lo(g, DATA_WIDTH);

        demux_channel_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (load[g]),
            .data_i     (in_data),
            .out_ready_i(out_ready[g]),
            .out_valid_o(out_valid[g]),
            .data_o     (output_lines[Lo +: DATA_WIDTH]),
            .free_o     (free[g])
        );
    end

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Scoreboard bench: 4-channel instance for routing/backpressure, 3-channel instance for drops.
module tb_stream_demux_1_to_n;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  select_lines;
    logic        broadcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] output_lines;
    logic        drop_err;
    logic [15:0] drop_count;

    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  select3;
    logic        broadcast3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] output_lines3;
    logic        drop_err3;
    logic [1:0]  drop_count3;

    int total;
    int bad;
    int pop_count [4];
    logic [7:0] exp_q [4][$];

    stream_demux_1_to_n #(
        .DATA_WIDTH    (8),
        .NUM_CHANNELS  (4),
        .DROP_CNT_WIDTH(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .select_lines(select_lines),
        .broadcast   (broadcast),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_lines(output_lines),
        .drop_err    (drop_err),
        .drop_count  (drop_count)
    );

    stream_demux_1_to_n #(
        .DATA_WIDTH    (8),
        .NUM_CHANNELS  (3),
        .DROP_CNT_WIDTH(2)
    ) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid3),
        .in_ready    (in_ready3),
        .in_data     (in_data3),
        .select_lines(select3),
        .broadcast   (broadcast3),
        .out_valid   (out_valid3),
        .out_ready   (out_ready3),
        .output_lines(output_lines3),
        .drop_err    (drop_err3),
        .drop_count  (drop_count3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Leaves the beat on the bus at negedge+1.
    task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic b);
        @(negedge clk);
        #1;
        in_valid     = 1'b1;
        in_data      = d;
        select_lines = s;
        broadcast    = b;
    endtask

    // Called at negedge+1; returns at the accepting posedge.
    task automatic wait_accept(input int budget, output int waited);
        waited = 0;
        #3;
        while (!in_ready && waited < budget) begin
            @(negedge clk);
            #4;
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got=in_ready_low want=accept within %0d", budget);
            in_valid = 1'b0;
        end else begin
            if (broadcast) begin
                for (int i = 0; i < 4; i++) exp_q[i].push_back(in_data);
            end else begin
                exp_q[select_lines].push_back(in_data);
            end
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: sample mid-cycle, pop on each handshake, idle slices must be zero.
    initial begin
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            #3;
            for (int i = 0; i < 4; i++) begin
                got = output_lines[i*8 +: 8];
                if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
                    total++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL ch%0d_unexpected: got=%0h want=none", i, got);
                    end else begin
                        want = exp_q[i].pop_front();
                        pop_count[i]++;
                        if (got !== want) begin
                            bad++;
                            $display("FAIL ch%0d_data: got=%0h want=%0h", i, got, want);
                        end
                    end
                end else if (out_valid[i] !== 1'b1) begin
                    total++;
                    if (out_valid[i] !== 1'b0 || got !== 8'h00) begin
                        bad++;
                        $display("FAIL ch%0d_idle: got=%b/%0h want=0/0", i, out_valid[i], got);
                    end
                end
            end
        end
    end

    initial begin
        int w;
        int start;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) pop_count[i] = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        select_lines = 2'd0;
        broadcast    = 1'b0;
        out_ready    = 4'hF;
        in_valid3    = 1'b0;
        in_data3     = 8'h00;
        select3      = 2'd0;
        broadcast3   = 1'b0;
        out_ready3   = 3'b111;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_lines", 64'(output_lines), 64'h0);
        check("rst_drop_count", 64'(drop_count), 64'h0);
        check("rst_drop_err", 64'(drop_err), 64'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Unicast sweep 11,22,33,44 to channels 0..3.
        for (int k = 0; k < 4; k++) begin
            drive(8'(8'h11 * (k + 1)), 2'(k), 1'b0);
            wait_accept(2, w);
            check("uni_ready", 64'(w), 64'h0);
        end
        idle();

        // Backpressure on channel 1; channel 3 still flows.
        drive(8'h5A, 2'd1, 1'b0);
        out_ready[1] = 1'b0;
        wait_accept(2, w);
        drive(8'h33, 2'd3, 1'b0);
        wait_accept(2, w);
        check("bp_other_ready", 64'(w), 64'h0);
        drive(8'h6B, 2'd1, 1'b0);
        #3;
        check("bp_ready_low", 64'(in_ready), 64'h0);
        check("bp_hold_valid", 64'(out_valid[1]), 64'h1);
        check("bp_hold_data", 64'(output_lines[15:8]), 64'h5A);
        @(negedge clk);
        #4;
        check("bp_ready_still_low", 64'(in_ready), 64'h0);
        check("bp_hold_data2", 64'(output_lines[15:8]), 64'h5A);
        @(negedge clk);
        #1;
        out_ready[1] = 1'b1;
        wait_accept(0, w);
        idle();
        #2;
        check("bp_no_gap_valid", 64'(out_valid[1]), 64'h1);
        check("bp_no_gap_data", 64'(output_lines[15:8]), 64'h6B);

        // Broadcast blocked by full channel 0, then all-or-nothing delivery.
        drive(8'h77, 2'd0, 1'b0);
        out_ready[0] = 1'b0;
        wait_accept(2, w);
        drive(8'hC3, 2'd0, 1'b1);
        #3;
        check("bc_ready_low", 64'(in_ready), 64'h0);
        check("bc_no_partial", 64'(out_valid), 64'h1);
        @(negedge clk);
        #4;
        check("bc_no_partial2", 64'(out_valid), 64'h1);
        @(negedge clk);
        #1;
        out_ready[0] = 1'b1;
        wait_accept(0, w);
        idle();
        #2;
        check("bc_all_valid", 64'(out_valid), 64'hF);
        check("bc_all_data", 64'(output_lines), 64'hC3C3_C3C3);

        // Throughput: 16 back-to-back beats to channel 0.
        start = pop_count[0];
        for (int k = 0; k < 16; k++) begin
            drive(8'(8'h80 + k), 2'd0, 1'b0);
            wait_accept(0, w);
        end
        idle();
        #3;
        check("tp_delivered", 64'(pop_count[0] - start), 64'd16);

        // Out-of-range drops on the 3-channel instance, counter saturates at 3.
        @(negedge clk);
        #1;
        in_valid3 = 1'b1;
        select3   = 2'b11;
        in_data3  = 8'hFF;
        #3;
        check("oor_ready", 64'(in_ready3), 64'h1);
        @(posedge clk);
        #1;
        check("oor_drop_err", 64'(drop_err3), 64'h1);
        check("oor_drop_count", 64'(drop_count3), 64'h1);
        check("oor_no_valid", 64'(out_valid3), 64'h0);
        @(negedge clk);
        #1;
        in_valid3 = 1'b0;
        @(posedge clk);
        #1;
        check("oor_err_once", 64'(drop_err3), 64'h0);
        @(negedge clk);
        #1;
        in_valid3 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        in_valid3 = 1'b0;
        @(posedge clk);
        #1;
        check("oor_saturate", 64'(drop_count3), 64'h3);
        check("oor_no_valid2", 64'(out_valid3), 64'h0);
        check("oor_lines_zero", 64'(output_lines3), 64'h0);
        check("main_no_drops", 64'(drop_count), 64'h0);

        // Asynchronous reset while channel 2 holds A5.
        drive(8'hA5, 2'd2, 1'b0);
        out_ready[2] = 1'b0;
        wait_accept(2, w);
        idle();
        #3;
        check("pre_rst_valid", 64'(out_valid), 64'h4);
        check("pre_rst_data", 64'(output_lines[23:16]), 64'hA5);
        #3;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_lines", 64'(output_lines), 64'h0);
        check("async_rst_count", 64'(drop_count), 64'h0);
        check("async_rst_count3", 64'(drop_count3), 64'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready[2] = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        check("post_rst_nothing", 64'(out_valid), 64'h0);

        repeat (3) @(negedge clk);
        #4;
        for (int i = 0; i < 4; i++) begin
            check("queue_drained", 64'(exp_q[i].size()), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
